// File: rtl/webfpga_button_scanner.sv
// Time-multiplexed button debouncer: one button is sampled per prescaler tick.
// Debounced level changes are reported through a small event FIFO.
module webfpga_button_scanner #(
    parameter int NUM_BTN    = 4,
    parameter int DIV        = 12000,
    parameter int FIFO_DEPTH = 4,
    localparam int IDW = (NUM_BTN > 2) ? $clog2(NUM_BTN) : 1,
    localparam int CW  = $clog2(DIV)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_in,
    output logic [NUM_BTN-1:0] btn_state,
    output logic               evt_valid,
    input  logic               evt_ready,
    output logic [IDW-1:0]     evt_id,
    output logic               evt_press,
    output logic               overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0]  CNT_MAX  = CW'(DIV - 1);
    localparam logic [IDW-1:0] PTR_MAX  = IDW'(NUM_BTN - 1);
    localparam logic [AW:0]    FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    logic [NUM_BTN-1:0] sync1_q, sync2_q;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [2:0]         hist_q [NUM_BTN];
    logic [2:0]         hist_d [NUM_BTN];
    logic [NUM_BTN-1:0] state_q, state_d;
    logic               eval_v_q, eval_v_d;
    logic [IDW-1:0]     eval_id_q, eval_id_d;
    logic [IDW:0]       fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]      wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]        fcnt_q, fcnt_d;
    logic               ovf_q, ovf_d;
    logic               tick_s, push_s, pop_s, full_s, accept_s, drop_s, cur_state_s;
    logic [2:0]         cur_hist_s;
    logic [IDW:0]       push_data_s;

    // Next-state logic for prescaler, scan pointer, histories, evaluation and queue.
    always_comb begin
        tick_s    = (cnt_q == CNT_MAX);
        cnt_d     = tick_s ? {CW{1'b0}} : cnt_q + CW'(1);
        hist_d    = hist_q;
        eval_v_d  = tick_s;
        if (tick_s) begin
            hist_d[ptr_q] = {hist_q[ptr_q][1:0], sync2_q[ptr_q]};
            eval_id_d     = ptr_q;
            ptr_d         = (ptr_q == PTR_MAX) ? {IDW{1'b0}} : ptr_q + IDW'(1);
        end else begin
            eval_id_d = eval_id_q;
            ptr_d     = ptr_q;
        end

        // The evaluated history was written on the previous (tick) edge.
        cur_hist_s  = hist_q[eval_id_q];
        cur_state_s = state_q[eval_id_q];
        state_d     = state_q;
        if (eval_v_q && (cur_hist_s == 3'b111) && !cur_state_s) begin
            state_d[eval_id_q] = 1'b1;
            push_s             = 1'b1;
        end else if (eval_v_q && (cur_hist_s == 3'b000) && cur_state_s) begin
            state_d[eval_id_q] = 1'b0;
            push_s             = 1'b1;
        end else begin
            push_s = 1'b0;
        end
        push_data_s = {eval_id_q, ~cur_state_s};

        pop_s    = (fcnt_q != {(AW + 1){1'b0}}) && evt_ready;
        full_s   = (fcnt_q == FULL_CNT);
        accept_s = push_s && (!full_s || pop_s);
        drop_s   = push_s && full_s && !pop_s;
        wr_d     = accept_s ? wr_q + AW'(1) : wr_q;
        rd_d     = pop_s ? rd_q + AW'(1) : rd_q;
        case ({accept_s, pop_s})
            2'b10:   fcnt_d = fcnt_q + (AW + 1)'(1);
            2'b01:   fcnt_d = fcnt_q - (AW + 1)'(1);
            default: fcnt_d = fcnt_q;
        endcase
        ovf_d = ovf_q | drop_s;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= {NUM_BTN{1'b0}};
            sync2_q   <= {NUM_BTN{1'b0}};
            cnt_q     <= {CW{1'b0}};
            ptr_q     <= {IDW{1'b0}};
            for (int i = 0; i < NUM_BTN; i++) hist_q[i] <= 3'b000;
            state_q   <= {NUM_BTN{1'b0}};
            eval_v_q  <= 1'b0;
            eval_id_q <= {IDW{1'b0}};
            wr_q      <= {AW{1'b0}};
            rd_q      <= {AW{1'b0}};
            fcnt_q    <= {(AW + 1){1'b0}};
            ovf_q     <= 1'b0;
        end else begin
            sync1_q   <= btn_in;
            sync2_q   <= sync1_q;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            hist_q    <= hist_d;
            state_q   <= state_d;
            eval_v_q  <= eval_v_d;
            eval_id_q <= eval_id_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            fcnt_q    <= fcnt_d;
            ovf_q     <= ovf_d;
        end
    end

    // Event storage; contents are only visible while the queue is non-empty.
    always_ff @(posedge clk) begin
        if (!rst && accept_s) begin
            fifo_mem[wr_q] <= push_data_s;
        end
    end

    assign btn_state           = state_q;
    assign overflow            = ovf_q;
    assign evt_valid           = (fcnt_q != {(AW + 1){1'b0}});
    assign {evt_id, evt_press} = evt_valid ? fifo_mem[rd_q] : {(IDW + 1){1'b0}};

endmodule

// File: tb/tb_webfpga_button_scanner.sv
// Randomised scoreboard bench for webfpga_button_scanner (NUM_BTN=4, DIV=4, FIFO_DEPTH=4).
module tb_webfpga_button_scanner;
    localparam int NB = 4;
    localparam int DV = 4;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [NB-1:0] btn;
    logic          evt_ready;
    logic [NB-1:0] btn_state;
    logic          evt_valid, evt_press, overflow;
    logic [1:0]    evt_id;

    webfpga_button_scanner #(.NUM_BTN(NB), .DIV(DV), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst(rst), .btn_in(btn), .btn_state(btn_state),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_id(evt_id),
        .evt_press(evt_press), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct { int id; bit press; } ev_t;
    ev_t     exp_q[$];
    int      n_chk = 0, n_fail = 0;
    bit      chk_en = 1'b0;

    // Reference model state: cycles since reset, per-button run of equal samples.
    int      cyc;
    logic [NB-1:0] rec [8];
    int      run [NB];
    bit      last [NB];
    bit [NB-1:0] st;
    int      occ;
    bit      ovf;
    bit      pend;
    int      pend_id;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: tick every DV cycles samples button (n-1)%NB using the level two edges earlier.
    always @(posedge clk) begin
        if (rst) begin
            cyc = 0; st = '0; occ = 0; ovf = 1'b0; pend = 1'b0;
            for (int k = 0; k < NB; k++) begin run[k] = 3; last[k] = 1'b0; end
            exp_q.delete();
            chk_en = 1'b1;
        end else begin
            cyc++;
            if (occ > 0 && evt_ready) occ--;
            if (pend) begin
                st[pend_id] = ~st[pend_id];
                pend = 1'b0;
                if (occ < FD) begin
                    occ++;
                    exp_q.push_back('{id: pend_id, press: st[pend_id]});
                end else begin
                    ovf = 1'b1;
                end
            end
            if (cyc % DV == 0) begin
                int k;
                bit s;
                k = (cyc / DV - 1) % NB;
                s = rec[(cyc - 2) % 8][k];
                if (last[k] == s) run[k]++;
                else begin run[k] = 1; last[k] = s; end
                if (run[k] >= 3 && last[k] != st[k]) begin
                    pend = 1'b1;
                    pend_id = k;
                end
            end
        end
        rec[cyc % 8] = btn;
    end

    // Monitor: compare DUT outputs against the model and the expected-event queue.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("btn_state", 32'(btn_state), 32'(st));
            chk("overflow", 32'(overflow), 32'(ovf));
            chk("evt_valid", 32'(evt_valid), 32'(occ != 0));
            if (evt_valid) begin
                if (exp_q.size() == 0) begin
                    chk("evt_unexpected", 32'(evt_valid), 32'd0);
                end else begin
                    chk("evt_id", 32'(evt_id), 32'(exp_q[0].id));
                    chk("evt_press", 32'(evt_press), 32'(exp_q[0].press));
                    if (evt_ready) void'(exp_q.pop_front());
                end
            end else begin
                chk("evt_empty_fields", 32'({evt_id, evt_press}), 32'd0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        bit got;
        rst = 1'b1; btn = '0; evt_ready = 1'b0;
        repeat (3) step();
        rst = 1'b0;

        // Held button 2 debounces and its press event is consumed at once.
        btn = 4'b0100; evt_ready = 1'b1;
        repeat (80) step();

        // Button 1 high for one sample window only: no state change.
        btn[1] = 1'b1;
        repeat (16) step();
        btn[1] = 1'b0;
        repeat (80) step();

        // Stalled consumer: five changes into a four-entry queue.
        pulse_rst();
        evt_ready = 1'b0; btn = 4'b1111;
        repeat (80) step();
        btn = 4'b1110;
        repeat (80) step();

        // Full queue with a pop on the same edge as a push.
        btn = 4'b0000;
        pulse_rst();
        evt_ready = 1'b0; btn = 4'b1111;
        repeat (80) step();
        btn = 4'b1101;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            step();
            if (pend && occ == FD) got = 1'b1;
        end
        chk("full_push_seen", 32'(got), 32'd1);
        evt_ready = 1'b1;
        step();
        evt_ready = 1'b0;
        repeat (20) step();

        // Reset with btn_state=1010 and two queued events; buttons re-debounce.
        btn = 4'b0000;
        pulse_rst();
        btn = 4'b1010;
        repeat (80) step();
        pulse_rst();
        repeat (80) step();

        // Random stimulus with occasional resets.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 15) == 0) btn[$urandom_range(0, NB - 1)] ^= 1'b1;
            evt_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1499) == 0) rst = 1'b1;
            else rst = 1'b0;
            step();
        end
        rst = 1'b0;

        // Drain everything still queued.
        evt_ready = 1'b1;
        repeat (100) step();
        chk("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
